// File: rtl/huffman_decode.sv
// Rebuilds 64 signed coefficients from one packed Huffman-coded 8x8 block, one coefficient per clock.
// Latency: done is high after the 66th rising edge counting the edge that samples start; an error ends the decode early.
// Backpressure: start is a level request taken only in IDLE; done holds the results until start is dropped.
module huffman_decode #(
    parameter int COEF_W   = 12,
    parameter int STREAM_W = 512,
    parameter int CNT_W    = 9
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [STREAM_W-1:0] data_in,
    input  logic [CNT_W-1:0]    num_bits,
    output logic [8*COEF_W-1:0] data_out0,
    output logic [8*COEF_W-1:0] data_out1,
    output logic [8*COEF_W-1:0] data_out2,
    output logic [8*COEF_W-1:0] data_out3,
    output logic [8*COEF_W-1:0] data_out4,
    output logic [8*COEF_W-1:0] data_out5,
    output logic [8*COEF_W-1:0] data_out6,
    output logic [8*COEF_W-1:0] data_out7,
    output logic [CNT_W-1:0]    bits_used,
    output logic                done,
    output logic                err
);

    typedef enum logic [1:0] {S_IDLE, S_DECODE, S_CHECK, S_DONE} state_t;

    state_t               state, state_nxt;
    logic [STREAM_W-1:0]  sr;
    logic [CNT_W-1:0]     nb_q;
    logic [9:0]           ptr;
    logic [5:0]           k;
    // Flat coefficient store; coefficient k lives at [767-12k -: 12], so row r is [767-96r -: 96].
    logic [64*COEF_W-1:0] coef_q;

    logic [19:0]          top;
    logic [3:0]           plen;
    logic [3:0]           cat;
    logic                 invalid;
    logic [10:0]          mag_win;
    logic [11:0]          v_ext;
    logic [11:0]          value;
    logic [4:0]           step;
    logic [10:0]          need;
    logic                 fail;
    logic [9:0]           base;

    assign top = sr[STREAM_W-1 -: 20];

    // Prefix lookup: category and prefix length from the leading code bits.
    always_comb begin
        plen    = 4'd0;
        cat     = 4'd0;
        invalid = 1'b0;
        casez (top[19:11])
            9'b00???????: begin plen = 4'd2; cat = 4'd0;  end
            9'b010??????: begin plen = 4'd3; cat = 4'd1;  end
            9'b011??????: begin plen = 4'd3; cat = 4'd2;  end
            9'b100??????: begin plen = 4'd3; cat = 4'd3;  end
            9'b101??????: begin plen = 4'd3; cat = 4'd4;  end
            9'b110??????: begin plen = 4'd3; cat = 4'd5;  end
            9'b1110?????: begin plen = 4'd4; cat = 4'd6;  end
            9'b11110????: begin plen = 4'd5; cat = 4'd7;  end
            9'b111110???: begin plen = 4'd6; cat = 4'd8;  end
            9'b1111110??: begin plen = 4'd7; cat = 4'd9;  end
            9'b11111110?: begin plen = 4'd8; cat = 4'd10; end
            9'b111111110: begin plen = 4'd9; cat = 4'd11; end
            default:      invalid = 1'b1;
        endcase
    end

    // Magnitude field and signed value; a leading 0 in the magnitude marks a negative value.
    always_comb begin
        mag_win = 11'((top << plen) >> 9);
        v_ext   = {1'b0, mag_win} >> (4'd11 - cat);
        value   = 12'd0;
        if (cat != 4'd0) begin
            if (mag_win[10])
                value = v_ext;
            else
                value = v_ext - ((12'd1 << cat) - 12'd1);
        end
        step = 5'(plen) + 5'(cat);
        need = {1'b0, ptr} + 11'(step);
        fail = invalid || (need > {2'b00, nb_q});
        base = 10'd756 - (10'(k) * 10'd12);
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state selection.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_DECODE;
            S_DECODE: begin
                if (fail)            state_nxt = S_DONE;
                else if (k == 6'd63) state_nxt = S_CHECK;
            end
            S_CHECK:  state_nxt = S_DONE;
            S_DONE:   if (!start) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded from state.
    always_comb begin
        done = (state == S_DONE);
    end

    // Datapath: load, per-coefficient decode and the final leftover-bit check.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr        <= '0;
            nb_q      <= '0;
            ptr       <= '0;
            k         <= '0;
            coef_q    <= '0;
            bits_used <= '0;
            err       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    sr     <= data_in;
                    nb_q   <= num_bits;
                    ptr    <= '0;
                    k      <= '0;
                    coef_q <= '0;
                    err    <= 1'b0;
                end
                S_DECODE: begin
                    if (fail) begin
                        err       <= 1'b1;
                        bits_used <= ptr[CNT_W-1:0];
                    end else begin
                        coef_q[base +: 12] <= value;
                        sr  <= sr << step;
                        ptr <= ptr + 10'(step);
                        k   <= k + 6'd1;
                    end
                end
                S_CHECK: begin
                    bits_used <= ptr[CNT_W-1:0];
                    err       <= (ptr != {1'b0, nb_q});
                end
                default: ;
            endcase
        end
    end

    assign data_out0 = coef_q[767:672];
    assign data_out1 = coef_q[671:576];
    assign data_out2 = coef_q[575:480];
    assign data_out3 = coef_q[479:384];
    assign data_out4 = coef_q[383:288];
    assign data_out5 = coef_q[287:192];
    assign data_out6 = coef_q[191:96];
    assign data_out7 = coef_q[95:0];

endmodule

// File: tb/tb_huffman_decode.sv
// Directed bench for huffman_decode: hand-computed streams and expected coefficients.
// Each scenario task drives its own stimulus and does its own comparisons.
// All waits are bounded by a cycle budget so the run always reaches the summary.
module tb_huffman_decode;

    logic         clk;
    logic         reset;
    logic         start;
    logic [511:0] data_in;
    logic [8:0]   num_bits;
    logic [95:0]  data_out0, data_out1, data_out2, data_out3;
    logic [95:0]  data_out4, data_out5, data_out6, data_out7;
    logic [8:0]   bits_used;
    logic         done;
    logic         err;

    int checks = 0;
    int errors = 0;

    logic [95:0] rows [8];
    assign rows[0] = data_out0;
    assign rows[1] = data_out1;
    assign rows[2] = data_out2;
    assign rows[3] = data_out3;
    assign rows[4] = data_out4;
    assign rows[5] = data_out5;
    assign rows[6] = data_out6;
    assign rows[7] = data_out7;

    huffman_decode dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .data_in   (data_in),
        .num_bits  (num_bits),
        .data_out0 (data_out0),
        .data_out1 (data_out1),
        .data_out2 (data_out2),
        .data_out3 (data_out3),
        .data_out4 (data_out4),
        .data_out5 (data_out5),
        .data_out6 (data_out6),
        .data_out7 (data_out7),
        .bits_used (bits_used),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Raises start and counts rising edges, including the sampling edge, until done is seen.
    // Stops at 200 edges so a stuck DUT shows up as a wrong edge count.
    task automatic launch(input logic [511:0] d, input logic [8:0] nb, output int edges);
        @(negedge clk);
        data_in  = d;
        num_bits = nb;
        start    = 1'b1;
        edges    = 0;
        while (edges < 200) begin
            @(posedge clk);
            edges++;
            #1;
            if (done) break;
        end
    endtask

    task automatic release_start();
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; data_in = '0; num_bits = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({done, err, bits_used} !== 11'd0) begin
            errors++;
            $display("FAIL reset_flags done/err/bits_used=%b/%b/%0d expected 0/0/0", done, err, bits_used);
        end
        for (int r = 0; r < 8; r++) begin
            checks++;
            if (rows[r] !== 96'd0) begin
                errors++;
                $display("FAIL reset_row%0d got %h expected 0", r, rows[r]);
            end
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_zero_stream();
        int e;
        launch(512'd0, 9'd128, e);
        checks++;
        if (e !== 66) begin errors++; $display("FAIL zero_latency edges=%0d expected 66", e); end
        checks++;
        if (err !== 1'b0 || bits_used !== 9'd128) begin
            errors++; $display("FAIL zero_status err=%b bits_used=%0d expected 0/128", err, bits_used);
        end
        for (int r = 0; r < 8; r++) begin
            checks++;
            if (rows[r] !== 96'd0) begin errors++; $display("FAIL zero_row%0d got %h expected 0", r, rows[r]); end
        end
    endtask

    // Entered with start still held high from the previous decode.
    task automatic test_handshake();
        data_in  = {9'h1FF, 503'd0};
        num_bits = 9'd7;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b1 || err !== 1'b0 || bits_used !== 9'd128) begin
            errors++; $display("FAIL hold_done done/err/bits_used=%b/%b/%0d expected 1/0/128", done, err, bits_used);
        end
        release_start();
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL drop_start done=%b expected 0", done); end
        checks++;
        if (bits_used !== 9'd128) begin errors++; $display("FAIL idle_hold bits_used=%0d expected 128", bits_used); end
    endtask

    task automatic test_mixed();
        int e;
        logic [95:0] exp0;
        exp0 = {12'hFFD, 12'h004, 72'd0};
        launch({11'b01100100100, 501'd0}, 9'd135, e);
        checks++;
        if (e !== 66) begin errors++; $display("FAIL mixed_latency edges=%0d expected 66", e); end
        checks++;
        if (data_out0 !== exp0) begin errors++; $display("FAIL mixed_row0 got %h expected %h", data_out0, exp0); end
        for (int r = 1; r < 8; r++) begin
            checks++;
            if (rows[r] !== 96'd0) begin errors++; $display("FAIL mixed_row%0d got %h expected 0", r, rows[r]); end
        end
        checks++;
        if (err !== 1'b0 || bits_used !== 9'd135) begin
            errors++; $display("FAIL mixed_status err=%b bits_used=%0d expected 0/135", err, bits_used);
        end
        release_start();
    endtask

    task automatic test_extreme();
        int e;
        launch({20'hFF7FF, 124'd0, 20'hFF000, 348'd0}, 9'd164, e);
        checks++;
        if (data_out0 !== {12'h7FF, 84'd0}) begin
            errors++; $display("FAIL extreme_row0 got %h expected %h", data_out0, {12'h7FF, 84'd0});
        end
        checks++;
        if (data_out7 !== {84'd0, 12'h801}) begin
            errors++; $display("FAIL extreme_row7 got %h expected %h", data_out7, {84'd0, 12'h801});
        end
        for (int r = 1; r < 7; r++) begin
            checks++;
            if (rows[r] !== 96'd0) begin errors++; $display("FAIL extreme_row%0d got %h expected 0", r, rows[r]); end
        end
        checks++;
        if (e !== 66 || err !== 1'b0 || bits_used !== 9'd164) begin
            errors++; $display("FAIL extreme_status edges=%0d err=%b bits_used=%0d expected 66/0/164", e, err, bits_used);
        end
        release_start();
    endtask

    task automatic test_invalid();
        int e;
        launch({9'h1FF, 503'd0}, 9'd200, e);
        checks++;
        if (e !== 2 || err !== 1'b1 || bits_used !== 9'd0) begin
            errors++; $display("FAIL invalid_prefix edges=%0d err=%b bits_used=%0d expected 2/1/0", e, err, bits_used);
        end
        for (int r = 0; r < 8; r++) begin
            checks++;
            if (rows[r] !== 96'd0) begin errors++; $display("FAIL invalid_row%0d got %h expected 0", r, rows[r]); end
        end
        release_start();
    endtask

    task automatic test_overread();
        int e;
        launch(512'd0, 9'd127, e);
        checks++;
        if (e !== 65 || err !== 1'b1 || bits_used !== 9'd126) begin
            errors++; $display("FAIL overread edges=%0d err=%b bits_used=%0d expected 65/1/126", e, err, bits_used);
        end
        checks++;
        if ((data_out0 | data_out7) !== 96'd0) begin
            errors++; $display("FAIL overread_rows got %h/%h expected 0", data_out0, data_out7);
        end
        release_start();
    endtask

    task automatic test_leftover();
        int e;
        launch(512'd0, 9'd130, e);
        checks++;
        if (e !== 66 || err !== 1'b1 || bits_used !== 9'd128) begin
            errors++; $display("FAIL leftover edges=%0d err=%b bits_used=%0d expected 66/1/128", e, err, bits_used);
        end
        release_start();
    endtask

    task automatic test_reset_mid_decode();
        int e;
        @(negedge clk);
        data_in  = {11'b01100100100, 501'd0};
        num_bits = 9'd135;
        start    = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        start = 1'b0;
        checks++;
        if (data_out0[95:84] !== 12'hFFD || done !== 1'b0) begin
            errors++; $display("FAIL mid_progress coef0=%h done=%b expected ffd/0", data_out0[95:84], done);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (data_out0 !== 96'd0 || bits_used !== 9'd0 || done !== 1'b0 || err !== 1'b0) begin
            errors++; $display("FAIL async_reset row0=%h bits_used=%0d done=%b err=%b expected all 0", data_out0, bits_used, done, err);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (80) @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || data_out0 !== 96'd0) begin
            errors++; $display("FAIL no_restart done=%b row0=%h expected 0/0", done, data_out0);
        end
        launch({11'b01100100100, 501'd0}, 9'd135, e);
        checks++;
        if (e !== 66 || data_out0 !== {12'hFFD, 12'h004, 72'd0} || err !== 1'b0 || bits_used !== 9'd135) begin
            errors++; $display("FAIL clean_restart edges=%0d row0=%h err=%b bits_used=%0d expected 66/ffd004.../0/135", e, data_out0, err, bits_used);
        end
        release_start();
    endtask

    initial begin
        test_reset();
        test_zero_stream();
        test_handshake();
        test_mixed();
        test_extreme();
        test_invalid();
        test_overread();
        test_leftover();
        test_reset_mid_decode();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
